// File: rtl/serial_subtractor_if.sv
// Handshake and operand/result bundle for the bit-serial subtractor.
// The controller side uses the master modport; the subtractor uses slave.
interface serial_subtractor_if #(
   parameter int unsigned WIDTH = 8
) ();
   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             b_in;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] diff;
   logic             b_out;

   modport master (
      output start, a, b, b_in,
      input  busy, done, diff, b_out
   );

   modport slave (
      input  start, a, b, b_in,
      output busy, done, diff, b_out
   );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial a - b - b_in, LSB first, one full-subtractor cell and a registered borrow.
// Results and handshake outputs are registered; diff/b_out hold until the next completion.
module serial_subtractor #(
   parameter int unsigned WIDTH = 8
) (
   input  logic              clk_i,
   input  logic              rst_i,
   serial_subtractor_if.slave sub_if
);

   localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

   state_e           state_q, state_d;
   logic [WIDTH-1:0] sa_q, sa_d;
   logic [WIDTH-1:0] sb_q, sb_d;
   logic [WIDTH-1:0] res_q, res_d;
   logic [WIDTH-1:0] diff_q, diff_d;
   logic [CntW-1:0]  cnt_q, cnt_d;
   logic             brw_q, brw_d;
   logic             b_out_q, b_out_d;
   logic             done_q, done_d;
   logic             busy_q, busy_d;

   logic d_bit;
   logic brw_bit;
   logic last_bit;

   // Full-subtractor cell on the current LSBs.
   assign d_bit    = sa_q[0] ^ sb_q[0] ^ brw_q;
   assign brw_bit  = (~sa_q[0] & sb_q[0]) | (~(sa_q[0] ^ sb_q[0]) & brw_q);
   assign last_bit = (cnt_q == CntW'(WIDTH - 1));

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:  if (sub_if.start) state_d = StShift;
         StShift: if (last_bit) state_d = StDone;
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      sa_d    = sa_q;
      sb_d    = sb_q;
      res_d   = res_q;
      brw_d   = brw_q;
      cnt_d   = cnt_q;
      diff_d  = diff_q;
      b_out_d = b_out_q;
      done_d  = 1'b0;
      busy_d  = (state_q != StIdle);
      unique case (state_q)
         StIdle: begin
            if (sub_if.start) begin
               sa_d  = sub_if.a;
               sb_d  = sub_if.b;
               brw_d = sub_if.b_in;
               cnt_d = '0;
            end
         end
         StShift: begin
            sa_d             = sa_q >> 1;
            sb_d             = sb_q >> 1;
            res_d            = res_q >> 1;
            res_d[WIDTH-1]   = d_bit;
            brw_d            = brw_bit;
            cnt_d            = cnt_q + 1'b1;
         end
         StDone: begin
            diff_d  = res_q;
            b_out_d = brw_q;
            done_d  = 1'b1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         sa_q    <= '0;
         sb_q    <= '0;
         res_q   <= '0;
         diff_q  <= '0;
         cnt_q   <= '0;
         brw_q   <= 1'b0;
         b_out_q <= 1'b0;
         done_q  <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         sa_q    <= sa_d;
         sb_q    <= sb_d;
         res_q   <= res_d;
         diff_q  <= diff_d;
         cnt_q   <= cnt_d;
         brw_q   <= brw_d;
         b_out_q <= b_out_d;
         done_q  <= done_d;
         busy_q  <= busy_d;
      end
   end

   assign sub_if.busy  = busy_q;
   assign sub_if.done  = done_q;
   assign sub_if.diff  = diff_q;
   assign sub_if.b_out = b_out_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor at WIDTH=8 and WIDTH=1 sharing one clock and reset.
module tb_serial_subtractor;

   typedef struct {
      logic [7:0] diff;
      logic       bout;
      int         cyc;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;
   int   n_checks = 0;
   int   n_fails = 0;

   exp_t q8[$];
   exp_t q1[$];
   exp_t e8, e1;
   logic prev8 = 1'b0;
   logic prev1 = 1'b0;
   logic [7:0] last8 = 8'd0;

   serial_subtractor_if #(.WIDTH(8)) bus8 ();
   serial_subtractor_if #(.WIDTH(1)) bus1 ();

   serial_subtractor #(.WIDTH(8)) u_dut8 (
      .clk_i  (clk),
      .rst_i  (rst),
      .sub_if (bus8)
   );

   serial_subtractor #(.WIDTH(1)) u_dut1 (
      .clk_i  (clk),
      .rst_i  (rst),
      .sub_if (bus1)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // Scoreboard consumers: every done must match the oldest outstanding expectation.
   always @(negedge clk) begin
      if (bus8.done) begin
         check_eq("w8_sb_nonempty", 32'(q8.size() > 0), 32'd1);
         check_eq("w8_done_gap", 32'(prev8), 32'd0);
         if (q8.size() > 0) begin
            e8 = q8.pop_front();
            check_eq("w8_diff", 32'(bus8.diff), 32'(e8.diff));
            check_eq("w8_b_out", 32'(bus8.b_out), 32'(e8.bout));
            check_eq("w8_latency", cyc, e8.cyc);
            check_eq("w8_busy_in_done", 32'(bus8.busy), 32'd1);
         end
      end
      prev8 = bus8.done;
   end

   always @(negedge clk) begin
      if (bus1.done) begin
         check_eq("w1_sb_nonempty", 32'(q1.size() > 0), 32'd1);
         check_eq("w1_done_gap", 32'(prev1), 32'd0);
         if (q1.size() > 0) begin
            e1 = q1.pop_front();
            check_eq("w1_diff", 32'(bus1.diff), 32'(e1.diff));
            check_eq("w1_b_out", 32'(bus1.b_out), 32'(e1.bout));
            check_eq("w1_latency", cyc, e1.cyc);
         end
      end
      prev1 = bus1.done;
   end

   task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic bin);
      int acc;
      int r;
      int busy_n;
      @(negedge clk);
      bus8.start = 1'b1;
      bus8.a     = a;
      bus8.b     = b;
      bus8.b_in  = bin;
      acc = cyc + 1;
      r   = int'(a) - int'(b) - int'(bin);
      q8.push_back('{diff: r[7:0], bout: (r < 0), cyc: acc + 9});
      busy_n = 0;
      for (int i = 0; i < 15; i++) begin
         @(negedge clk);
         if (i == 0) begin
            bus8.start = 1'b0;
            bus8.a     = 8'($urandom);
            bus8.b     = 8'($urandom);
            bus8.b_in  = 1'($urandom);
         end
         if (i == 3) check_eq("w8_diff_hold", 32'(bus8.diff), 32'(last8));
         if (bus8.busy) busy_n++;
      end
      check_eq("w8_busy_cycles", busy_n, 9);
      check_eq("w8_drained", q8.size(), 0);
      last8 = r[7:0];
   endtask

   task automatic op1(input logic a, input logic b, input logic bin);
      int acc;
      int r;
      int busy_n;
      @(negedge clk);
      bus1.start = 1'b1;
      bus1.a     = a;
      bus1.b     = b;
      bus1.b_in  = bin;
      acc = cyc + 1;
      r   = int'(a) - int'(b) - int'(bin);
      q1.push_back('{diff: {7'd0, r[0]}, bout: (r < 0), cyc: acc + 2});
      busy_n = 0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         if (i == 0) bus1.start = 1'b0;
         if (bus1.busy) busy_n++;
      end
      check_eq("w1_busy_cycles", busy_n, 2);
      check_eq("w1_drained", q1.size(), 0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int acc;
      int r;
      bus8.start = 1'b0; bus8.a = '0; bus8.b = '0; bus8.b_in = 1'b0;
      bus1.start = 1'b0; bus1.a = '0; bus1.b = '0; bus1.b_in = 1'b0;
      repeat (3) @(negedge clk);
      check_eq("rst_busy", 32'(bus8.busy), 32'd0);
      check_eq("rst_done", 32'(bus8.done), 32'd0);
      check_eq("rst_diff", 32'(bus8.diff), 32'd0);
      check_eq("rst_b_out", 32'(bus8.b_out), 32'd0);
      rst = 1'b0;

      op8(8'd5, 8'd3, 1'b0);
      op8(8'd3, 8'd5, 1'b0);
      op8(8'd0, 8'd0, 1'b1);
      op8(8'hFF, 8'hFF, 1'b0);
      op8(8'hA5, 8'h3C, 1'b1);

      // A second start while shifting must be dropped, not queued.
      @(negedge clk);
      bus8.start = 1'b1; bus8.a = 8'h40; bus8.b = 8'h01; bus8.b_in = 1'b0;
      acc = cyc + 1;
      q8.push_back('{diff: 8'h3F, bout: 1'b0, cyc: acc + 9});
      @(negedge clk); bus8.start = 1'b0;
      @(negedge clk);
      @(negedge clk); bus8.start = 1'b1; bus8.a = 8'h00; bus8.b = 8'hFF;
      @(negedge clk); bus8.start = 1'b0;
      repeat (14) @(negedge clk);
      check_eq("ign_drained", q8.size(), 0);
      check_eq("ign_diff_held", 32'(bus8.diff), 32'h3F);
      last8 = 8'h3F;

      // Reset mid-operation, with start also high: no done, everything cleared.
      @(negedge clk);
      bus8.start = 1'b1; bus8.a = 8'h80; bus8.b = 8'h01; bus8.b_in = 1'b0;
      @(negedge clk); bus8.start = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b1; bus8.start = 1'b1;
      @(negedge clk);
      rst = 1'b0; bus8.start = 1'b0;
      check_eq("abort_busy", 32'(bus8.busy), 32'd0);
      check_eq("abort_done", 32'(bus8.done), 32'd0);
      check_eq("abort_diff", 32'(bus8.diff), 32'd0);
      check_eq("abort_b_out", 32'(bus8.b_out), 32'd0);
      repeat (14) @(negedge clk);
      check_eq("abort_still_idle", 32'(bus8.busy), 32'd0);
      // Reset and start together while idle: start must not be accepted.
      rst = 1'b1; bus8.start = 1'b1;
      @(negedge clk);
      rst = 1'b0; bus8.start = 1'b0;
      @(negedge clk);
      check_eq("rst_start_busy", 32'(bus8.busy), 32'd0);
      last8 = 8'd0;
      op8(8'd9, 8'd4, 1'b0);

      // Start held high: accepted every WIDTH+2 cycles.
      @(negedge clk);
      bus8.start = 1'b1; bus8.a = 8'h12; bus8.b = 8'h34; bus8.b_in = 1'b1;
      acc = cyc + 1;
      r   = 32'h12 - 32'h34 - 1;
      for (int k = 0; k < 3; k++) q8.push_back('{diff: r[7:0], bout: 1'b1, cyc: acc + 10 * k + 9});
      repeat (21) @(negedge clk);
      bus8.start = 1'b0;
      repeat (15) @(negedge clk);
      check_eq("b2b_drained", q8.size(), 0);

      for (int i = 0; i < 8; i++) begin
         logic [2:0] v;
         v = 3'(i);
         op1(v[2], v[1], v[0]);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
